// File: rtl/mem_pkg.sv
// mem_pkg: FSM state encoding and address-width helpers shared by the result-matrix
// read and write address generators.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2_min1(input int v);
    int w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int rw_width(input int m, input int n);
    return clog2_min1(m / n);
  endfunction

  function automatic int cw_width(input int m);
    return clog2_min1(m);
  endfunction

  function automatic int aw_width(input int m, input int n);
    return clog2_min1((m * m) / n);
  endfunction

endpackage

// File: rtl/mem_wr_skew.sv
// mem_wr_skew: valid-tagged shift register; stage j+1 takes stage j every cycle, so
// stage k is the beat accepted k+1 cycles ago.
module mem_wr_skew #(
  parameter int DEPTH = 3,
  parameter int PW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic [PW-1:0]            i_payload,
  output logic [DEPTH-1:0]         o_valid,
  output logic [DEPTH-1:0][PW-1:0] o_payload
);

  logic [DEPTH-1:0]         r_valid;
  logic [DEPTH-1:0][PW-1:0] r_payload;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_payload <= '0;
    end else begin
      r_valid[0]   <= i_valid;
      r_payload[0] <= i_payload;
      for (int j = 1; j < DEPTH; j++) begin
        r_valid[j]   <= r_valid[j-1];
        r_payload[j] <= r_payload[j-1];
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/mem_write_res.sv
// mem_write_res: write-side address generator for the result banks; lane k of each beat
// is written to bank k k+1 cycles after acceptance. Optional err port: MEM_WRITE_RES_ERR_EN.
module mem_write_res
  import mem_pkg::*;
#(
  parameter int  D_W = 32,
  parameter int  N   = 3,
  parameter int  M   = 6,
  localparam int AW  = aw_width(M, N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [N*D_W-1:0] in_data,
  output logic             in_ready,
  output logic [N*AW-1:0]  wr_addr,
  output logic [N*D_W-1:0] wr_data,
  output logic [N-1:0]     wr_en,
  output logic             busy,
  output logic             done
`ifdef MEM_WRITE_RES_ERR_EN
  , output logic           err
`endif
);

  localparam int RW   = rw_width(M, N);
  localparam int CW   = cw_width(M);
  localparam int PW   = AW + N * D_W;
  localparam int CNTW = clog2_min1(N + 1);
  localparam int ROWS = M / N;

  state_t              r_state;
  state_t              w_state_next;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [CNTW-1:0]     r_drain_cnt;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;
  logic                w_accept;
  logic                w_last_beat;
  logic [AW-1:0]       w_addr;
  logic [PW-1:0]       w_skew_in;
  logic [N-1:0]        w_stg_valid;
  logic [N-1:0][PW-1:0] w_stg_payload;
  logic                w_lanes_unused;

  assign w_accept    = in_valid && r_in_ready;
  assign w_last_beat = w_accept && (r_row == RW'(ROWS - 1)) && (r_col == CW'(M - 1));
  assign w_addr      = AW'((int'(r_row) * M) + int'(r_col));
  assign w_skew_in   = w_accept ? {w_addr, in_data} : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN; else w_state_next = IDLE;
      RUN:     if (w_last_beat) w_state_next = DRAIN; else w_state_next = RUN;
      // Leave once this cycle's decrement empties the counter.
      DRAIN:   if (r_drain_cnt <= CNTW'(1)) w_state_next = DONE; else w_state_next = DRAIN;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_row <= '0;
          r_col <= '0;
        end
        RUN: begin
          if (w_accept) begin
            if (r_col == CW'(M - 1)) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        default: begin
          r_row <= r_row;
          r_col <= r_col;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
    end else if (w_last_beat) begin
      r_drain_cnt <= CNTW'(N);
    end else if (r_state == DRAIN) begin
      r_drain_cnt <= r_drain_cnt - CNTW'(1);
    end else begin
      r_drain_cnt <= r_drain_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= (w_state_next == RUN);
      r_busy     <= (w_state_next == RUN) || (w_state_next == DRAIN);
      r_done     <= (w_state_next == DONE);
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;

  mem_wr_skew #(
    .DEPTH (N),
    .PW    (PW)
  ) u_skew (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (w_accept),
    .i_payload (w_skew_in),
    .o_valid   (w_stg_valid),
    .o_payload (w_stg_payload)
  );

  for (genvar k = 0; k < N; k++) begin : g_tap
    assign wr_en[k]                = w_stg_valid[k];
    assign wr_addr[k*AW +: AW]     = w_stg_payload[k][PW-1 -: AW];
    assign wr_data[k*D_W +: D_W]   = w_stg_payload[k][k*D_W +: D_W];
  end

  assign w_lanes_unused = ^w_stg_payload;

`ifdef MEM_WRITE_RES_ERR_EN
  logic r_err;

  // Sticky flag for beats offered outside RUN; an accepted start takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_err <= 1'b0;
    end else if (in_valid && (r_state != RUN)) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_mem_write_res.sv
// tb_mem_write_res: directed + randomized stores checked every cycle against a beat-indexed
// write schedule model. Defining MEM_WRITE_RES_ERR_EN also checks the err port.
module tb_mem_write_res;

  localparam int D_W   = 32;
  localparam int N     = 3;
  localparam int M     = 6;
  localparam int AW    = mem_pkg::aw_width(M, N);
  localparam int TOTAL = (M * M) / N;
  localparam int MAXC  = 4000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic [N*D_W-1:0] in_data;
  logic             in_ready;
  logic [N*AW-1:0]  wr_addr;
  logic [N*D_W-1:0] wr_data;
  logic [N-1:0]     wr_en;
  logic             busy;
  logic             done;
`ifdef MEM_WRITE_RES_ERR_EN
  logic             err;
`endif

  mem_write_res #(.D_W(D_W), .N(N), .M(M)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done)
`ifdef MEM_WRITE_RES_ERR_EN
    , .err    (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [N-1:0]   exp_en   [MAXC];
  logic [AW-1:0]  exp_addr [MAXC][N];
  logic [D_W-1:0] exp_data [MAXC][N];
  bit             exp_busy [MAXC];
  bit             exp_done [MAXC];
  bit             exp_ready[MAXC];
  bit             exp_err  [MAXC];
  logic [N-1:0]   obs_en   [MAXC];
  logic [AW-1:0]  obs_addr [MAXC][N];
  logic [D_W-1:0] obs_data [MAXC][N];
  logic           obs_done [MAXC];

  function automatic void check(input string name, input int c, input logic [63:0] got,
                                input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, got, want);
    end
  endfunction

  function automatic int count_wr(input int k, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (obs_en[i][k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (obs_done[i] === 1'b1) n++;
    return n;
  endfunction

  // Model: beat b of a store lands at address b in every bank, bank k one cycle later per lane.
  initial begin : cmp_proc
    int m_phase, m_beats, m_idle_at;
    bit m_err;
    m_phase = 0; m_beats = 0; m_idle_at = 0; m_err = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      exp_en[i] = '0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_ready[i] = 1'b0;
      exp_err[i] = 1'b0; obs_en[i] = '0; obs_done[i] = 1'b0;
      for (int k = 0; k < N; k++) begin
        exp_addr[i][k] = '0; exp_data[i][k] = '0; obs_addr[i][k] = '0; obs_data[i][k] = '0;
      end
    end
    forever begin
      @(negedge clk);
      if (cyc < MAXC - N - 4) begin
        check("wr_en", cyc, 64'(wr_en), 64'(exp_en[cyc]));
        for (int k = 0; k < N; k++) begin
          obs_addr[cyc][k] = wr_addr[k*AW +: AW];
          obs_data[cyc][k] = wr_data[k*D_W +: D_W];
          if (exp_en[cyc][k]) begin
            check($sformatf("wr_addr%0d", k), cyc, 64'(wr_addr[k*AW +: AW]), 64'(exp_addr[cyc][k]));
            check($sformatf("wr_data%0d", k), cyc, 64'(wr_data[k*D_W +: D_W]), 64'(exp_data[cyc][k]));
          end
        end
        obs_en[cyc]   = wr_en;
        obs_done[cyc] = done;
        check("busy", cyc, 64'(busy), 64'(exp_busy[cyc]));
        check("done", cyc, 64'(done), 64'(exp_done[cyc]));
        check("in_ready", cyc, 64'(in_ready), 64'(exp_ready[cyc]));
`ifdef MEM_WRITE_RES_ERR_EN
        check("err", cyc, 64'(err), 64'(exp_err[cyc]));
`endif
        if (!rst_n) begin
          m_phase = 0; m_beats = 0; m_err = 1'b0;
          for (int i = cyc + 1; i <= cyc + N + 2; i++) begin
            exp_en[i] = '0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_ready[i] = 1'b0;
          end
        end else begin
          case (m_phase)
            0: begin
              if (start) begin
                m_phase = 1; m_err = 1'b0;
              end else if (in_valid) begin
                m_err = 1'b1;
              end
            end
            1: begin
              if (in_valid) begin
                for (int k = 0; k < N; k++) begin
                  exp_en[cyc+1+k][k]   = 1'b1;
                  exp_addr[cyc+1+k][k] = AW'(m_beats);
                  exp_data[cyc+1+k][k] = in_data[k*D_W +: D_W];
                end
                m_beats++;
                if (m_beats == TOTAL) begin
                  m_phase = 2; m_beats = 0; m_idle_at = cyc + N + 2;
                  for (int i = 1; i <= N; i++) exp_busy[cyc+i] = 1'b1;
                  exp_done[cyc+N+1] = 1'b1;
                end
              end
            end
            default: begin
              if (in_valid) m_err = 1'b1;
              if (cyc + 1 >= m_idle_at) m_phase = 0;
            end
          endcase
          if (m_phase == 1) begin
            exp_busy[cyc+1]  = 1'b1;
            exp_ready[cyc+1] = 1'b1;
          end
        end
        exp_err[cyc+1] = m_err;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      start = 1'b0; in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 40 && dc < 0; i++) begin
      if (done === 1'b1) dc = cyc;
      else tick();
    end
    if (dc < 0) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout cyc=%0d got=no_done want=done", cyc);
    end
  endtask

  // gap_pct < 0 alternates valid/idle; fixed data uses 3F800000 + beat*16 + lane.
  task automatic do_store(input int gap_pct, input bit fixed, input int rstart_beat,
                          input bit stray_tail, output int s, output int dc);
    int sent = 0;
    int it   = 0;
    tick();
    start = 1'b1; in_valid = 1'b0; s = cyc;
    while (sent < TOTAL && it < 400) begin
      tick();
      start    = (sent == rstart_beat);
      in_valid = (gap_pct < 0) ? (it % 2 == 0) : ($urandom_range(0, 99) >= gap_pct);
      for (int k = 0; k < N; k++)
        in_data[k*D_W +: D_W] = fixed ? 32'h3F80_0000 + 32'(sent * 16 + k) : $urandom;
      if (in_valid) sent++;
      it++;
    end
    if (sent < TOTAL) begin
      n_vec++; n_bad++;
      $display("FAIL feed_timeout cyc=%0d got=%0d want=%0d", cyc, sent, TOTAL);
    end
    tick();
    start = 1'b0; in_valid = stray_tail;
    wait_done(dc);
    idle(3);
  endtask

  initial begin : stim
    int s, dc, r, s2;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    idle(2);

    // Back-to-back store with the recognisable data pattern.
    do_store(0, 1'b1, -1, 1'b0, s, dc);
    check("t1_done_cycle", s, 64'(dc), 64'(s + 16));
    for (int k = 0; k < N; k++) check($sformatf("t1_writes%0d", k), s, 64'(count_wr(k, s, s + 18)), 64'd12);
    check("t1_wrap_en", s + 8, 64'(obs_en[s+8][0]), 64'd1);
    check("t1_wrap_addr", s + 8, 64'(obs_addr[s+8][0]), 64'd6);
    check("t1_last_addr2", s + 15, 64'(obs_addr[s+15][2]), 64'd11);
    check("t1_data_b6_l1", s + 9, 64'(obs_data[s+9][1]), 64'h3F80_0061);

    // Alternating valid: twelve beats spread over 23 cycles.
    do_store(-1, 1'b1, -1, 1'b0, s, dc);
    check("t2_done_cycle", s, 64'(dc), 64'(s + 27));
    for (int k = 0; k < N; k++) check($sformatf("t2_writes%0d", k), s, 64'(count_wr(k, s, s + 30)), 64'd12);

    // Reset after beat 5, then a fresh store.
    tick(); start = 1'b1; s = cyc;
    for (int b = 0; b < 6; b++) begin
      tick(); start = 1'b0; in_valid = 1'b1; in_data = {3{$urandom}};
    end
    tick(); rst_n = 1'b0; in_valid = 1'b1; r = cyc;
    tick(); rst_n = 1'b1; in_valid = 1'b0;
    check("rst_wr_en", cyc, 64'(wr_en), 64'd0);
    check("rst_wr_addr", cyc, 64'(wr_addr), 64'd0);
    check("rst_wr_data", cyc, 64'(wr_data), 64'd0);
    check("rst_busy", cyc, 64'(busy), 64'd0);
    check("rst_in_ready", cyc, 64'(in_ready), 64'd0);
    idle(6);
    for (int k = 0; k < N; k++) check($sformatf("rst_nowr%0d", k), r, 64'(count_wr(k, r + 1, r + 6)), 64'd0);
    do_store(0, 1'b0, -1, 1'b0, s2, dc);
    check("rst_new_en0", s2 + 2, 64'(obs_en[s2+2][0]), 64'd1);
    check("rst_new_addr0", s2 + 2, 64'(obs_addr[s2+2][0]), 64'd0);

    // start during RUN at beat 3 is ignored.
    do_store(0, 1'b0, 3, 1'b0, s, dc);
    check("t4_done_cycle", s, 64'(dc), 64'(s + 16));
    check("t4_done_count", s, 64'(count_done(s, s + 19)), 64'd1);
    for (int k = 0; k < N; k++) check($sformatf("t4_writes%0d", k), s, 64'(count_wr(k, s, s + 19)), 64'd12);

    // Stray beats in IDLE, then a start that coincides with a stray beat.
    tick(); in_valid = 1'b1; in_data = {3{$urandom}}; r = cyc;
    tick(); tick();
    tick(); in_valid = 1'b0;
    idle(4);
    for (int k = 0; k < N; k++) check($sformatf("stray_nowr%0d", k), r, 64'(count_wr(k, r, r + 7)), 64'd0);
`ifdef MEM_WRITE_RES_ERR_EN
    check("stray_err_set", cyc, 64'(err), 64'd1);
`endif
    tick(); start = 1'b1; in_valid = 1'b1; s = cyc;
    tick(); start = 1'b0; in_valid = 1'b0;
`ifdef MEM_WRITE_RES_ERR_EN
    check("stray_err_clr", cyc, 64'(err), 64'd0);
`endif
    check("stray_start_busy", cyc, 64'(busy), 64'd1);
    for (int b = 0; b < TOTAL; b++) begin
      tick(); in_valid = 1'b1; in_data = {3{$urandom}};
    end
    tick(); in_valid = 1'b0;
    wait_done(dc);
    check("t5_done_cycle", s, 64'(dc), 64'(s + 17));
    idle(2);

    // Randomized stores: gaps, ignored starts, stray tail beats.
    for (int n = 0; n < 30; n++) begin
      do_store($urandom_range(0, 60), 1'b0,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, TOTAL - 1) : -1,
               $urandom_range(0, 1) == 1, s, dc);
    end

    // Randomized aborts by reset mid-store.
    for (int n = 0; n < 5; n++) begin
      tick(); start = 1'b1; in_valid = 1'b0;
      for (int b = 0; b < int'($urandom_range(1, 2 * TOTAL - 2)); b++) begin
        tick(); start = 1'b0; in_valid = $urandom_range(0, 1) == 1; in_data = {3{$urandom}};
      end
      tick(); rst_n = 1'b0; in_valid = 1'b0;
      tick(); rst_n = 1'b1;
      idle(5);
    end

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
